dm_load_unit: RTL and testbench

//  Read-side companion of the data-memory store merger. Accepts one load request at a time
//  (lw/lh/lb/lhu/lbu), issues a word-aligned read to data memory over a req/ack handshake,
//  and returns the selected byte/halfword sign- or zero-extended to 32 bits.

---
 rtl/dm_load_unit.sv | 153 +++++++++++++++
 tb/tb_dm_load_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dm_load_unit.sv
//==============================================================================
// Module   : dm_load_unit
// Brief    : Single-outstanding data-memory load unit with byte/half extraction,
//            misalignment detection and a bounded wait for the memory ack.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module dm_load_unit #(
   parameter int MAX_WAIT = 255,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_start,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_type,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        ld_busy,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        ld_misalign,
   output logic        ld_timeout
);

   localparam logic [2:0] T_LW  = 3'd0;
   localparam logic [2:0] T_LH  = 3'd1;
   localparam logic [2:0] T_LB  = 3'd2;
   localparam logic [2:0] T_LHU = 3'd3;
   localparam logic [2:0] T_LBU = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic [1:0]       addr_lo;
   logic [2:0]       type_q;
   logic             req_err;
   logic             expire;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      ext_data;

   // Errors are judged on the incoming request so that no memory access is issued.
   always_comb begin
      req_err = 1'b0;
      case (ld_type)
         T_LW:          req_err = (ld_addr[1:0] != 2'b00);
         T_LH, T_LHU:   req_err = ld_addr[0];
         T_LB, T_LBU:   req_err = 1'b0;
         default:       req_err = 1'b1;
      endcase
   end

   assign expire = (wait_cnt == CNT_W'(MAX_WAIT - 1));

   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (addr_lo)
         2'b00:   byte_sel = mem_rdata[7:0];
         2'b01:   byte_sel = mem_rdata[15:8];
         2'b10:   byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (type_q)
         T_LH:    ext_data = {{16{half_sel[15]}}, half_sel};
         T_LB:    ext_data = {{24{byte_sel[7]}}, byte_sel};
         T_LHU:   ext_data = {16'h0000, half_sel};
         T_LBU:   ext_data = {24'h000000, byte_sel};
         default: ext_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (ld_start) state_next = req_err ? DONE : REQ;
         // An ack on the expiring edge still completes normally.
         REQ:  if (mem_ack || expire) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req     <= 1'b0;
         mem_addr    <= 32'h0;
         ld_data     <= 32'h0;
         ld_misalign <= 1'b0;
         ld_timeout  <= 1'b0;
         wait_cnt    <= '0;
         addr_lo     <= 2'b00;
         type_q      <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (ld_start) begin
                  addr_lo  <= ld_addr[1:0];
                  type_q   <= ld_type;
                  wait_cnt <= '0;
                  if (req_err) begin
                     ld_misalign <= 1'b1;
                     ld_data     <= 32'h0;
                  end else begin
                     mem_req  <= 1'b1;
                     mem_addr <= {ld_addr[31:2], 2'b00};
                  end
               end
            end
            REQ: begin
               if (mem_ack) begin
                  ld_data <= ext_data;
                  mem_req <= 1'b0;
               end else if (expire) begin
                  ld_data    <= 32'h0;
                  ld_timeout <= 1'b1;
                  mem_req    <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               ld_misalign <= 1'b0;
               ld_timeout  <= 1'b0;
            end
            default: begin
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign ld_busy  = (state != IDLE);
   assign ld_valid = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_dm_load_unit.sv
//==============================================================================
// Module   : tb_dm_load_unit
// Brief    : Directed and random load transactions compared against a reference.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_dm_load_unit;

   localparam int MAX_WAIT = 6;
   localparam int CNT_W    = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_start;
   logic [31:0] ld_addr;
   logic [2:0]  ld_type;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        ld_busy;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_misalign;
   logic        ld_timeout;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] last_data = 32'h0;

   dm_load_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .ld_start(ld_start), .ld_addr(ld_addr),
      .ld_type(ld_type), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ld_busy(ld_busy),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_misalign(ld_misalign),
      .ld_timeout(ld_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: {error, result} from the ISA-level load rules.
   function automatic logic [32:0] model(input logic [2:0] t, input logic [31:0] a,
                                         input logic [31:0] d);
      logic [31:0] b, h, r;
      logic        err;
      b   = (d >> (8 * (a % 4))) & 32'hFF;
      h   = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      err = 1'b0;
      r   = 32'h0;
      case (t)
         3'd0: begin err = (a % 4) != 0; r = d; end
         3'd1: begin err = (a % 2) != 0; r = (h >= 32768) ? h + 32'hFFFF_0000 : h; end
         3'd2: r = (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd3: begin err = (a % 2) != 0; r = h; end
         3'd4: r = b;
         default: err = 1'b1;
      endcase
      if (err) r = 32'h0;
      return {err, r};
   endfunction

   // Called one time unit after an edge; returns one time unit after the DONE->IDLE edge.
   task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                          input int ack_delay, input bit noise, input bit start_in_done);
      logic [32:0] exp;
      int          n;
      bit          addr_ok;
      bit          req_ok;
      bit          to_exp;
      exp = model(t, a, d);
      check("idle_busy", {31'd0, ld_busy}, 32'd0);
      ld_start = 1'b1; ld_addr = a; ld_type = t;
      @(posedge clk); #1;
      ld_start = 1'b0;
      if (exp[32]) begin
         check("err_valid", {31'd0, ld_valid}, 32'd1);
         check("err_misalign", {31'd0, ld_misalign}, 32'd1);
         check("err_noreq", {31'd0, mem_req}, 32'd0);
         check("err_data", ld_data, 32'h0);
         last_data = 32'h0;
      end else begin
         to_exp  = (ack_delay >= MAX_WAIT);
         n       = 0;
         addr_ok = 1'b1;
         req_ok  = 1'b1;
         while (!ld_valid && n < 100) begin
            if (mem_req !== 1'b1) req_ok = 1'b0;
            if (mem_addr !== (a & 32'hFFFF_FFFC)) addr_ok = 1'b0;
            mem_ack   = (n == ack_delay);
            mem_rdata = (n == ack_delay) ? d : $urandom;
            if (noise) begin
               ld_start = 1'($urandom_range(0, 1));
               ld_addr  = $urandom;
               ld_type  = 3'($urandom_range(0, 7));
            end
            n++;
            @(posedge clk); #1;
            mem_ack = 1'b0; ld_start = 1'b0;
         end
         check("req_held", {31'd0, req_ok}, 32'd1);
         check("addr_stable", {31'd0, addr_ok}, 32'd1);
         check("req_cycles", n, to_exp ? MAX_WAIT : ack_delay + 1);
         check("valid", {31'd0, ld_valid}, 32'd1);
         check("req_dropped", {31'd0, mem_req}, 32'd0);
         check("timeout", {31'd0, ld_timeout}, {31'd0, to_exp});
         check("misalign", {31'd0, ld_misalign}, 32'd0);
         last_data = to_exp ? 32'h0 : exp[31:0];
         check("data", ld_data, last_data);
      end
      if (start_in_done) begin
         ld_start = 1'b1; ld_addr = 32'h0000_0100; ld_type = 3'd0;
      end
      @(posedge clk); #1;
      ld_start = 1'b0;
      check("valid_pulse", {31'd0, ld_valid}, 32'd0);
      check("flags_clr", {30'd0, ld_misalign, ld_timeout}, 32'd0);
      check("back_idle", {30'd0, ld_busy, mem_req}, 32'd0);
      check("data_held", ld_data, last_data);
   endtask

   initial begin
      reset = 1'b1; ld_start = 1'b0; ld_addr = 32'h0; ld_type = 3'd0;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_outputs", {27'd0, mem_req, ld_busy, ld_valid, ld_misalign, ld_timeout}, 32'd0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_data", ld_data, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_load(3'd2, 32'h0000_1003, 32'h80FF_1234, 0, 1'b0, 1'b0);
      check("lb_result", ld_data, 32'hFFFF_FF80);
      do_load(3'd3, 32'h0000_2002, 32'h9ABC_5678, 5, 1'b0, 1'b0);
      check("lhu_result", ld_data, 32'h0000_9ABC);
      do_load(3'd0, 32'h0000_3001, 32'h1111_1111, 0, 1'b0, 1'b0);
      do_load(3'd6, 32'h0000_3000, 32'h1111_1111, 0, 1'b0, 1'b0);
      do_load(3'd1, 32'h0000_4000, 32'h2222_2222, 99, 1'b0, 1'b0);
      do_load(3'd4, 32'h0000_5001, 32'hDEAD_BEEF, 2, 1'b1, 1'b1);
      do_load(3'd0, 32'h0000_5004, 32'hCAFE_F00D, 1, 1'b1, 1'b0);
      check("b2b_result", ld_data, 32'hCAFE_F00D);

      // Reset in the middle of a request, with an ack arriving afterwards.
      ld_start = 1'b1; ld_addr = 32'h0000_6000; ld_type = 3'd0;
      @(posedge clk); #1;
      ld_start = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("rst_mid_req", {30'd0, mem_req, ld_busy}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("late_ack", {29'd0, mem_req, ld_busy, ld_valid}, 32'd0);
      check("rst_data_clr", ld_data, 32'h0);
      last_data = 32'h0;

      for (int i = 0; i < 60; i++) begin
         logic [2:0] t;
         t = 3'($urandom_range(0, 7));
         do_load(t, $urandom, $urandom, $urandom_range(0, MAX_WAIT + 1),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
